// File: rtl/crc_chk_pkg.sv
// Shared types and constants for the CRC frame checker.
package crc_chk_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam logic [31:0] CRC32_POLY_ETH  = 32'h04C11DB7;
  localparam int unsigned TIMEOUT_CYC_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_CRC,
    ST_REPORT
  } chk_state_e;

  typedef enum logic [1:0] {
    RES_OK,
    RES_ERR,
    RES_RUNT,
    RES_TIMEOUT
  } chk_result_e;

endpackage

// File: rtl/crc_chk_sat_cnt.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module crc_chk_sat_cnt
  import crc_chk_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Count one event per enabled cycle, holding at the maximum value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/crc_frame_checker.sv
// Frame checker: forwards payload words to an external CRC32 engine, keeps
// the trailing FCS word, and reports ok / error / runt / timeout per frame.
module crc_frame_checker
  import crc_chk_pkg::*;
#(
  parameter logic [DATA_W-1:0] POLY        = CRC32_POLY_ETH,
  parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] eng_data_o,
  output logic              eng_valid_o,
  output logic              eng_last_o,
  output logic [DATA_W-1:0] eng_poly_o,
  input  logic [DATA_W-1:0] eng_crc_i,
  input  logic              eng_crc_valid_i,
  output logic              result_valid_o,
  output logic              crc_ok_o,
  output logic              crc_err_o,
  output logic              runt_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  ok_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  // Last wait-counter value before the engine is declared silent.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  chk_state_e        state_q, state_d;
  chk_result_e       result_q;
  logic              ready_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] fcs_q;
  logic [31:0]       wait_cnt_q;
  logic [DATA_W-1:0] eng_data_p1;
  logic              eng_vld_p1;
  logic              eng_last_p1;
  logic              accept;
  logic              timeout_hit;
  logic              report;
  logic              ok_inc;
  logic              err_inc;

  // Ready is a flop, so acceptance never depends combinationally on state decode.
  assign accept      = s_valid_i && ready_q;
  assign timeout_hit = (wait_cnt_q == TO_LAST);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = s_last_i ? ST_REPORT : ST_STREAM;
      ST_STREAM:   if (accept && s_last_i) state_d = ST_WAIT_CRC;
      ST_WAIT_CRC: if (eng_crc_valid_i || timeout_hit) state_d = ST_REPORT;
      ST_REPORT:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register; ready follows the state being entered so it is low in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_STREAM);
    end
  end

  // Frame datapath: one-word hold so the FCS never reaches the engine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      fcs_q       <= '0;
      wait_cnt_q  <= '0;
      result_q    <= RES_OK;
      eng_data_p1 <= '0;
      eng_vld_p1  <= 1'b0;
      eng_last_p1 <= 1'b0;
    end else begin
      eng_vld_p1  <= 1'b0;
      eng_last_p1 <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wait_cnt_q <= '0;
          if (accept) begin
            if (s_last_i) result_q <= RES_RUNT;
            else          hold_q   <= s_data_i;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            eng_vld_p1  <= 1'b1;
            eng_last_p1 <= s_last_i;
            eng_data_p1 <= hold_q;
            if (s_last_i) fcs_q  <= s_data_i;
            else          hold_q <= s_data_i;
          end
        end
        ST_WAIT_CRC: begin
          // An engine answer in the final cycle beats the timeout.
          if (eng_crc_valid_i) begin
            result_q <= (eng_crc_i == fcs_q) ? RES_OK : RES_ERR;
          end else if (timeout_hit) begin
            result_q <= RES_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign report  = (state_q == ST_REPORT);
  assign ok_inc  = report && (result_q == RES_OK);
  assign err_inc = report && (result_q != RES_OK);

  crc_chk_sat_cnt #(.W(CNT_W)) u_ok_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ok_inc),
    .cnt_o  (ok_cnt_o)
  );

  crc_chk_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (err_inc),
    .cnt_o  (err_cnt_o)
  );

  assign s_ready_o      = ready_q;
  assign eng_data_o     = eng_data_p1;
  assign eng_valid_o    = eng_vld_p1;
  assign eng_last_o     = eng_last_p1;
  assign eng_poly_o     = POLY;
  assign result_valid_o = report;
  assign crc_ok_o       = report && (result_q == RES_OK);
  assign crc_err_o      = report && (result_q == RES_ERR);
  assign runt_o         = report && (result_q == RES_RUNT);
  assign timeout_o      = report && (result_q == RES_TIMEOUT);

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker with an engine stub and frame model.
module tb_crc_frame_checker;

  localparam int          T    = 32;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  // Expected flag vectors, ordered {timeout, runt, err, ok}.
  localparam logic [3:0] F_OK   = 4'b0001;
  localparam logic [3:0] F_ERR  = 4'b0010;
  localparam logic [3:0] F_RUNT = 4'b0100;
  localparam logic [3:0] F_TO   = 4'b1000;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] s_data_i;
  logic        s_valid_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic [31:0] eng_data_o;
  logic        eng_valid_o;
  logic        eng_last_o;
  logic [31:0] eng_poly_o;
  logic [31:0] eng_crc_i;
  logic        eng_crc_valid_i;
  logic        result_valid_o;
  logic        crc_ok_o;
  logic        crc_err_o;
  logic        runt_o;
  logic        timeout_o;
  logic [15:0] ok_cnt_o;
  logic [15:0] err_cnt_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_ok   = '0;
  logic [15:0] exp_err  = '0;
  logic [32:0] eng_q[$];
  logic [31:0] fq[$];

  typedef struct {
    string      name;
    int         n_words;
    int         delay;
    bit         crc_match;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t tbl[6];

  crc_frame_checker #(.POLY(POLY), .TIMEOUT_CYC(T)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .s_data_i        (s_data_i),
    .s_valid_i       (s_valid_i),
    .s_last_i        (s_last_i),
    .s_ready_o       (s_ready_o),
    .eng_data_o      (eng_data_o),
    .eng_valid_o     (eng_valid_o),
    .eng_last_o      (eng_last_o),
    .eng_poly_o      (eng_poly_o),
    .eng_crc_i       (eng_crc_i),
    .eng_crc_valid_i (eng_crc_valid_i),
    .result_valid_o  (result_valid_o),
    .crc_ok_o        (crc_ok_o),
    .crc_err_o       (crc_err_o),
    .runt_o          (runt_o),
    .timeout_o       (timeout_o),
    .ok_cnt_o        (ok_cnt_o),
    .err_cnt_o       (err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Engine-side monitor: records every forwarded word with its last flag.
  always @(negedge clk_i) begin
    if (rst_ni && eng_valid_o) eng_q.push_back({eng_last_o, eng_data_o});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference outcome of a frame from its length, engine delay and CRC values.
  function automatic logic [3:0] model_result(input int n_words, input int delay,
                                              input logic [31:0] crc, input logic [31:0] fcs);
    if (n_words == 1) return F_RUNT;
    if (delay >= T)   return F_TO;
    return (crc == fcs) ? F_OK : F_ERR;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Present one word from a negedge and hold it until accepted.
  task automatic send_word(input logic [31:0] d, input logic l);
    int g;
    g = 0;
    s_data_i  = d;
    s_last_i  = l;
    s_valid_i = 1'b1;
    while (!s_ready_o && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check("s_ready_o before word", 32'(s_ready_o), 32'd1);
    @(negedge clk_i);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_data_i  = '0;
  endtask

  task automatic wait_result(input int bound, output int cyc);
    cyc = 0;
    while (!result_valid_o && cyc < bound) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [31:0] w[$], input int delay,
                           input logic [31:0] crc_ret, input logic [3:0] exp_flags,
                           input bit bubbles);
    int n;
    int cyc;
    bit early;
    n = w.size();
    eng_q.delete();
    for (int i = 0; i < n; i++) begin
      if (bubbles) repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send_word(w[i], (i == n - 1));
    end
    if (n == 1) begin
      wait_result(4, cyc);
      check({tag, " runt report seen"}, 32'(cyc < 3), 32'd1);
    end else if (delay < T) begin
      check({tag, " s_ready_o in WAIT_CRC"}, 32'(s_ready_o), 32'd0);
      early = 1'b0;
      repeat (delay) begin
        if (result_valid_o) early = 1'b1;
        @(negedge clk_i);
      end
      if (result_valid_o) early = 1'b1;
      eng_crc_i       = crc_ret;
      eng_crc_valid_i = 1'b1;
      @(negedge clk_i);
      eng_crc_valid_i = 1'b0;
      eng_crc_i       = '0;
      check({tag, " no early result"}, 32'(early), 32'd0);
      check({tag, " result_valid one cycle after crc_valid"}, 32'(result_valid_o), 32'd1);
    end else begin
      wait_result(T + 8, cyc);
      check({tag, " cycles to timeout report"}, 32'(cyc), 32'(T));
    end
    check({tag, " flags {to,runt,err,ok}"},
          32'({timeout_o, runt_o, crc_err_o, crc_ok_o}), 32'(exp_flags));
    if (exp_flags == F_OK) exp_ok = sat16(exp_ok);
    else                   exp_err = sat16(exp_err);
    @(negedge clk_i);
    check({tag, " outputs low after report"},
          32'({result_valid_o, timeout_o, runt_o, crc_err_o, crc_ok_o}), 32'd0);
    check({tag, " ok_cnt"}, 32'(ok_cnt_o), 32'(exp_ok));
    check({tag, " err_cnt"}, 32'(err_cnt_o), 32'(exp_err));
    if (n > 1 && delay >= T) begin
      eng_crc_i       = crc_ret;
      eng_crc_valid_i = 1'b1;
      @(negedge clk_i);
      eng_crc_valid_i = 1'b0;
      eng_crc_i       = '0;
      early = result_valid_o;
      @(negedge clk_i);
      early = early | result_valid_o;
      check({tag, " late crc_valid ignored"}, 32'(early), 32'd0);
      check({tag, " err_cnt after late pulse"}, 32'(err_cnt_o), 32'(exp_err));
    end
    check({tag, " engine pulse count"}, 32'(eng_q.size()), 32'(n - 1));
    for (int i = 0; i < n - 1 && i < eng_q.size(); i++) begin
      check({tag, " engine word"}, eng_q[i][31:0], w[i]);
      check({tag, " engine last"}, 32'(eng_q[i][32]), 32'(i == n - 2));
    end
  endtask

  initial begin
    int          cyc;
    bit          seen;
    logic [31:0] fcs;
    logic [31:0] crc;
    logic [3:0]  exp;

    rst_ni          = 1'b0;
    s_data_i        = '0;
    s_valid_i       = 1'b0;
    s_last_i        = 1'b0;
    eng_crc_i       = '0;
    eng_crc_valid_i = 1'b0;

    // Reset state
    repeat (5) @(negedge clk_i);
    check("reset control outputs",
          32'({s_ready_o, eng_valid_o, eng_last_o, result_valid_o,
               crc_ok_o, crc_err_o, runt_o, timeout_o}), 32'd0);
    check("reset eng_data_o", eng_data_o, 32'd0);
    check("reset ok_cnt_o", 32'(ok_cnt_o), 32'd0);
    check("reset err_cnt_o", 32'(err_cnt_o), 32'd0);
    check("eng_poly_o", eng_poly_o, POLY);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("s_ready_o in IDLE after release", 32'(s_ready_o), 32'd1);

    // Reset in the middle of a frame: no report, counters untouched
    eng_q.delete();
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("async reset clears handshake/engine",
          32'({s_ready_o, eng_valid_o, eng_last_o, result_valid_o}), 32'd0);
    check("async reset clears eng_data_o", eng_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      if (result_valid_o) seen = 1'b1;
    end
    check("mid-frame reset gives no report", 32'(seen), 32'd0);
    check("mid-frame reset ok_cnt", 32'(ok_cnt_o), 32'(exp_ok));
    check("mid-frame reset err_cnt", 32'(err_cnt_o), 32'(exp_err));

    // Reference good frame
    fq = '{32'h90ABCDEF, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h46FD7AA9};
    run_frame("good", fq, 2, 32'h46FD7AA9, F_OK, 1'b0);

    // Reference bad frame
    fq = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_frame("bad", fq, 1, 32'hA008D0FB, F_ERR, 1'b0);

    // Runt
    fq = '{32'hAAAAAAAA};
    run_frame("runt", fq, 0, 32'h0, F_RUNT, 1'b0);

    // Silent engine, then a late answer
    fq = '{32'hDEADBEEF, 32'hCAFEF00D};
    run_frame("timeout", fq, T, 32'hCAFEF00D, F_TO, 1'b0);

    // Boundary table
    tbl[0] = '{"delay0",     3, 0,     1'b1, F_OK};
    tbl[1] = '{"delay5_bad", 4, 5,     1'b0, F_ERR};
    tbl[2] = '{"delayT-1",   2, T - 1, 1'b1, F_OK};
    tbl[3] = '{"delayT",     2, T,     1'b1, F_TO};
    tbl[4] = '{"runt_rand",  1, 0,     1'b1, F_RUNT};
    tbl[5] = '{"long",       12, 3,    1'b1, F_OK};
    for (int k = 0; k < 6; k++) begin
      fq.delete();
      for (int i = 0; i < tbl[k].n_words; i++) fq.push_back($urandom);
      fcs = fq[fq.size() - 1];
      crc = tbl[k].crc_match ? fcs : (fcs ^ ($urandom | 32'd1));
      run_frame(tbl[k].name, fq, tbl[k].delay, crc, tbl[k].exp_flags, 1'b1);
    end

    // Randomized frames against the model
    for (int f = 0; f < 25; f++) begin
      int n;
      int d;
      n = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(2, 7));
      d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 2, T + 1))
                                      : int'($urandom_range(0, 6));
      fq.delete();
      for (int i = 0; i < n; i++) fq.push_back($urandom);
      fcs = fq[n - 1];
      crc = ($urandom_range(0, 1) == 1) ? fcs : (fcs ^ ($urandom | 32'd1));
      exp = model_result(n, d, crc, fcs);
      run_frame("random", fq, d, crc, exp, 1'b1);
    end

    cyc = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
